// File: rtl/eth_fcs_inserter_if.sv
// ---------------------------------------------------------------------------
// eth_fcs_inserter_if
// Byte-wide AXI-stream bundle used on both sides of the FCS inserter.
//   tvalid : byte valid (master -> slave)
//   tready : byte accepted (slave -> master)
//   tlast  : last byte of frame (master -> slave)
//   tdata  : frame byte (master -> slave)
// Modports: master drives valid/last/data, slave drives ready.
// ---------------------------------------------------------------------------
interface eth_fcs_inserter_if;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic [7:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/eth_fcs_inserter.sv
// ---------------------------------------------------------------------------
// eth_fcs_inserter
// Transmit-path framer stage: passes an 8-bit frame stream through with zero
// latency, optionally zero-pads short frames to MIN_FRAME_BYTES, then appends
// the 4-byte IEEE 802.3 FCS (reflected CRC-32, low byte first). tlast is
// carried only on the final FCS byte.
//
// Ports:
//   clk      : clock
//   sresetn  : synchronous active-low reset; also gates all handshake outputs
//   axis_i   : slave stream from the MAC header/payload assembler
//   axis_o   : master stream towards the PHY-side byte interface
//
// Parameters:
//   MIN_FRAME_BYTES : minimum frame length excluding FCS (padding builds only)
//   LEN_W           : byte counter width; the counter saturates at 2^LEN_W-1
//
// Build option:
//   ETH_FCS_INSERTER_PAD_EN : when defined, short frames are zero-padded and
//   the pad bytes are covered by the FCS. When undefined, every frame goes
//   straight from DATA to FCS unpadded.
// ---------------------------------------------------------------------------
module eth_fcs_inserter #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int LEN_W           = 16
) (
    input  logic                       clk,
    input  logic                       sresetn,
    eth_fcs_inserter_if.slave          axis_i,
    eth_fcs_inserter_if.master         axis_o
);

`ifdef ETH_FCS_INSERTER_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_PAD  = 2'd1,
        ST_FCS  = 2'd2
    } state_t;

    // One byte through the reflected CRC-32 (poly 0x04C11DB7, LSB first).
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] r;
        r = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    state_t           state_q;
    logic [31:0]      crc_q;
    logic [1:0]       idx_q;
    logic [LEN_W-1:0] cnt_q;

    logic             in_ready;
    logic             out_valid;
    logic             out_last;
    logic [7:0]       out_data;
    logic             xfer;
    logic [31:0]      crc_d;
    logic [31:0]      fcs;
    logic [LEN_W:0]   cnt_plus;
    logic [LEN_W-1:0] cnt_d;
    logic             frame_short;
    logic             pad_done;

    assign fcs         = ~crc_q;
    assign cnt_plus    = {1'b0, cnt_q} + (LEN_W+1)'(1);
    // Saturating increment: long frames keep the counter pinned, so they
    // can never look short and are never padded.
    assign cnt_d       = (&cnt_q) ? cnt_q : cnt_plus[LEN_W-1:0];
    assign frame_short = PAD_EN && (cnt_plus < (LEN_W+1)'(MIN_FRAME_BYTES));
    assign pad_done    = (cnt_plus == (LEN_W+1)'(MIN_FRAME_BYTES));

    // Handshake outputs are decoded from state and forced idle while in reset,
    // so a reset mid-frame silences the output without waiting for an edge.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 8'h00;
        if (sresetn) begin
            case (state_q)
                ST_DATA: begin
                    out_data  = axis_i.tdata;
                    out_valid = axis_i.tvalid;
                    in_ready  = axis_o.tready;
                end
                ST_PAD: begin
                    out_valid = 1'b1;
                end
                ST_FCS: begin
                    out_valid = 1'b1;
                    out_data  = fcs[8*idx_q +: 8];
                    out_last  = (idx_q == 2'd3);
                end
                default: begin
                    out_valid = 1'b0;
                end
            endcase
        end
    end

    assign xfer  = out_valid && axis_o.tready;
    // The CRC covers exactly what leaves on axis_o (data or pad zeros).
    assign crc_d = crc32_byte(crc_q, out_data);

    assign axis_i.tready = in_ready;
    assign axis_o.tvalid = out_valid;
    assign axis_o.tlast  = out_last;
    assign axis_o.tdata  = out_data;

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q <= ST_DATA;
            crc_q   <= 32'hFFFFFFFF;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
        end else if (xfer) begin
            case (state_q)
                ST_DATA: begin
                    crc_q <= crc_d;
                    cnt_q <= cnt_d;
                    if (axis_i.tlast) begin
                        idx_q   <= 2'd0;
                        state_q <= frame_short ? ST_PAD : ST_FCS;
                    end
                end
                ST_PAD: begin
                    crc_q <= crc_d;
                    cnt_q <= cnt_d;
                    if (pad_done) begin
                        idx_q   <= 2'd0;
                        state_q <= ST_FCS;
                    end
                end
                ST_FCS: begin
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_q <= ST_DATA;
                        crc_q   <= 32'hFFFFFFFF;
                        cnt_q   <= '0;
                        idx_q   <= 2'd0;
                    end
                end
                default: begin
                    state_q <= ST_DATA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_fcs_inserter.sv
// ---------------------------------------------------------------------------
// tb_eth_fcs_inserter
// Scoreboard bench: each frame issued pushes its expected output beats
// (data, optional padding, FCS with tlast on the last byte) into a queue; an
// independent monitor compares every presented output beat to the queue head
// and pops it on transfer.
// ---------------------------------------------------------------------------
module tb_eth_fcs_inserter;

    localparam int MIN_BYTES = 60;

`ifdef ETH_FCS_INSERTER_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic clk = 1'b0;
    logic sresetn;
    always #5 clk = ~clk;

    eth_fcs_inserter_if in_if ();
    eth_fcs_inserter_if out_if ();

    eth_fcs_inserter #(
        .MIN_FRAME_BYTES (MIN_BYTES),
        .LEN_W           (16)
    ) dut (
        .clk     (clk),
        .sresetn (sresetn),
        .axis_i  (in_if),
        .axis_o  (out_if)
    );

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    bit    rand_ready = 1'b0;
    bit    b2b_chk    = 1'b0;
    bit    after_tlast = 1'b0;
    int    last_tlast_cyc = 0;
    beat_t e;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference CRC: bit-serial reflected LFSR.
    function automatic logic [31:0] ref_crc(input logic [7:0] f[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (f[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ f[i][b];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    task automatic push_frame(input logic [7:0] f[$]);
        logic [7:0]  all[$];
        logic [31:0] fcs;
        beat_t       b;
        all = f;
        if (PAD_ON) begin
            while (all.size() < MIN_BYTES) all.push_back(8'h00);
        end
        fcs = ~ref_crc(all);
        foreach (all[i]) begin
            b.d = all[i]; b.l = 1'b0;
            exp_q.push_back(b);
        end
        for (int k = 0; k < 4; k++) begin
            b.d = fcs[8*k +: 8]; b.l = (k == 3);
            exp_q.push_back(b);
        end
    endtask

    task automatic push_raw(input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d; b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit hold);
        int t;
        foreach (f[i]) begin
            in_if.tvalid = 1'b1;
            in_if.tdata  = f[i];
            in_if.tlast  = (i == f.size() - 1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!in_if.tready && t < 5000);
            if (!in_if.tready) begin
                n_vec++; n_err++;
                $display("FAIL in_handshake_timeout byte %0d: tready=%b required 1", i, in_if.tready);
            end
            @(posedge clk); #1;
        end
        if (!hold) begin
            in_if.tvalid = 1'b0;
            in_if.tlast  = 1'b0;
            in_if.tdata  = 8'h00;
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (sresetn && out_if.tvalid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got %02h last=%b, required none", out_if.tdata, out_if.tlast);
                end else begin
                    e = exp_q[0];
                    if (out_if.tdata !== e.d || out_if.tlast !== e.l) begin
                        n_err++;
                        $display("FAIL out_beat: got %02h last=%b, required %02h last=%b",
                                 out_if.tdata, out_if.tlast, e.d, e.l);
                    end
                    if (out_if.tready) begin
                        void'(exp_q.pop_front());
                        if (b2b_chk && after_tlast) begin
                            n_vec++;
                            if (cyc - last_tlast_cyc != 1) begin
                                n_err++;
                                $display("FAIL b2b_gap: got %0d cycles, required 1", cyc - last_tlast_cyc);
                            end
                        end
                        after_tlast = e.l;
                        if (e.l) last_tlast_cyc = cyc;
                    end
                end
            end
        end
    end

    // Random downstream backpressure while enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_if.tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [7:0] f[$];
        logic [7:0] g[$];

        sresetn       = 1'b0;
        in_if.tvalid  = 1'b1;
        in_if.tlast   = 1'b1;
        in_if.tdata   = 8'h5A;
        out_if.tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (out_if.tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b required 0", out_if.tvalid); end
        n_vec++; if (out_if.tlast  !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b required 0", out_if.tlast); end
        n_vec++; if (out_if.tdata  !== 8'h00) begin n_err++; $display("FAIL rst_tdata: got %02h required 00", out_if.tdata); end
        n_vec++; if (in_if.tready  !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b required 0", in_if.tready); end
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
        in_if.tdata  = 8'h00;
        @(posedge clk); #1;
        sresetn = 1'b1;
        @(posedge clk); #1;

        // "123456789": check value CBF43926 -> FCS bytes 26 39 F4 CB.
        f = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        if (PAD_ON) begin
            push_frame(f);
        end else begin
            foreach (f[i]) push_raw(f[i], 1'b0);
            push_raw(8'h26, 1'b0);
            push_raw(8'h39, 1'b0);
            push_raw(8'hF4, 1'b0);
            push_raw(8'hCB, 1'b1);
        end
        send_frame(f, 1'b0);
        drain("crc_check");

        // Single-byte frame.
        f = {8'hAB};
        push_frame(f);
        send_frame(f, 1'b0);
        drain("one_byte");

        // Exactly minimum length and one byte short.
        f.delete();
        for (int i = 0; i < 60; i++) f.push_back(8'(i * 7 + 3));
        push_frame(f);
        send_frame(f, 1'b0);
        drain("len60");
        void'(f.pop_back());
        push_frame(f);
        send_frame(f, 1'b0);
        drain("len59");

        // Random backpressure across data, pad and FCS.
        rand_ready = 1'b1;
        f.delete();
        for (int i = 0; i < 20; i++) f.push_back(8'(8'hC0 ^ i));
        push_frame(f);
        send_frame(f, 1'b0);
        f = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        push_frame(f);
        send_frame(f, 1'b0);
        drain("backpressure");
        rand_ready = 1'b0;
        @(posedge clk); #1;
        out_if.tready = 1'b1;
        @(posedge clk); #1;

        // Back-to-back 64-byte frames with input valid held high.
        f.delete();
        g.delete();
        for (int i = 0; i < 64; i++) begin
            f.push_back(8'(i));
            g.push_back(8'(255 - 3 * i));
        end
        after_tlast = 1'b0;
        b2b_chk     = 1'b1;
        push_frame(f);
        push_frame(g);
        send_frame(f, 1'b1);
        send_frame(g, 1'b0);
        drain("b2b");
        b2b_chk = 1'b0;

        // Reset while the second FCS byte is on the output.
        f.delete();
        for (int i = 0; i < 60; i++) f.push_back(8'(8'h80 + i));
        push_frame(f);
        repeat (3) void'(exp_q.pop_back());
        send_frame(f, 1'b0);
        @(posedge clk); #1;
        sresetn = 1'b0;
        @(negedge clk);
        n_vec++; if (out_if.tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_tvalid: got %b required 0", out_if.tvalid); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL midrst_pending: got %0d beats required 0", exp_q.size()); end
        @(posedge clk); #1;
        exp_q.delete();
        sresetn = 1'b1;
        @(posedge clk); #1;
        f.delete();
        for (int i = 0; i < 60; i++) f.push_back(8'(8'h3C ^ (i * 5)));
        push_frame(f);
        send_frame(f, 1'b0);
        drain("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
